// File: rtl/silly_pkg.sv
// silly_pkg: shared definitions for the silly response checker.
//   chk_state_t  - checker FSM states (IDLE, RUN, DONE)
//   NUM_COMBOS   - number of distinct {a,b,c} input combinations
//   silly_golden - golden function of the silly block, usable by RTL and benches
package silly_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } chk_state_t;

  localparam int unsigned NUM_COMBOS = 8;

  // True for {a,b,c} = 000, 100, 101.
  function automatic logic silly_golden(input logic a, input logic b, input logic c);
    return (~b & ~c) | (a & ~b);
  endfunction

endpackage

// File: rtl/silly_ref_model.sv
// silly_ref_model: combinational reference for the silly block.
// Ports:
//   a_i, b_i, c_i - stimulus bits
//   y_exp_o       - expected response of silly for that stimulus
module silly_ref_model
  import silly_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_exp_o
);

  always_comb begin
    y_exp_o = silly_golden(a_i, b_i, c_i);
  end

endmodule

// File: rtl/silly_checker.sv
// silly_checker: response checker / scoreboard for the silly combinational block.
// Accepts one sampled vector (a, b, c, y) per clock while running, compares y against the
// golden function, counts vectors and mismatches and captures the first failing vector.
//
// Optional feature macro: SILLY_CHK_COVERAGE_EN
//   defined   - cov_map_o / cov_full_o are live and pass_o also requires full coverage
//   undefined - no coverage register; cov_map_o = 8'h00, cov_full_o = 0
//
// Parameters:
//   NUM_VECTORS - vectors per run (1 .. 2^CNT_W-1)
//   CNT_W       - width of counters and index
// Ports:
//   clk_i, reset_ni      - rising-edge clock, asynchronous active-low reset
//   start_i              - clears all results and (re)enters RUN
//   valid_i              - a_i, b_i, c_i, y_i valid this cycle
//   a_i, b_i, c_i, y_i   - stimulus applied to silly and its observed response
//   busy_o, done_o       - in RUN / in DONE
//   pass_o               - run finished cleanly (and fully covered, if coverage built)
//   vec_cnt_o, err_cnt_o - accepted vectors / saturating mismatch count
//   err_seen_o           - at least one mismatch this run
//   first_err_vec_o/idx_o- {a,b,c} and vec_cnt of the first mismatch
//   cov_map_o, cov_full_o- input combinations seen / all eight seen
module silly_checker
  import silly_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 11,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_seen_o,
  output logic [2:0]       first_err_vec_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [7:0]       cov_map_o,
  output logic             cov_full_o
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LastVec = CNT_W'(NUM_VECTORS);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic [2:0]       first_err_vec_q, first_err_vec_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;

  logic       y_exp;
  logic [2:0] abc;
  logic       accept;
  logic       mismatch;

  silly_ref_model u_ref_model (
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .y_exp_o (y_exp)
  );

  assign abc      = {a_i, b_i, c_i};
  // start has priority: a colliding vector is discarded.
  assign accept   = (state_q == RUN) && valid_i && !start_i;
  assign mismatch = (y_i != y_exp);

  always_comb begin
    state_d         = state_q;
    vec_cnt_d       = vec_cnt_q;
    err_cnt_d       = err_cnt_q;
    err_seen_d      = err_seen_q;
    first_err_vec_d = first_err_vec_q;
    first_err_idx_d = first_err_idx_q;

    if (start_i) begin
      vec_cnt_d       = '0;
      err_cnt_d       = '0;
      err_seen_d      = 1'b0;
      first_err_vec_d = '0;
      first_err_idx_d = '0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + CntOne;
      if (mismatch) begin
        if (err_cnt_q != CntMax) begin
          err_cnt_d = err_cnt_q + CntOne;
        end
        if (!err_seen_q) begin
          err_seen_d      = 1'b1;
          first_err_vec_d = abc;
          first_err_idx_d = vec_cnt_q;
        end
      end
    end

    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (start_i) begin
          state_d = RUN;
        end else if (accept && (vec_cnt_d == LastVec)) begin
          state_d = DONE;
        end
      end
      DONE:    if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= IDLE;
      vec_cnt_q       <= '0;
      err_cnt_q       <= '0;
      err_seen_q      <= 1'b0;
      first_err_vec_q <= '0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      vec_cnt_q       <= vec_cnt_d;
      err_cnt_q       <= err_cnt_d;
      err_seen_q      <= err_seen_d;
      first_err_vec_q <= first_err_vec_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign vec_cnt_o       = vec_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign err_seen_o      = err_seen_q;
  assign first_err_vec_o = first_err_vec_q;
  assign first_err_idx_o = first_err_idx_q;

`ifdef SILLY_CHK_COVERAGE_EN
  logic [NUM_COMBOS-1:0] cov_q, cov_d;

  always_comb begin
    cov_d = cov_q;
    if (start_i) begin
      cov_d = '0;
    end else if (accept) begin
      cov_d[abc] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cov_q <= '0;
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov_map_o  = cov_q;
  assign cov_full_o = &cov_q;
  assign pass_o     = done_o && (err_cnt_q == '0) && cov_full_o;
`else
  assign cov_map_o  = 8'h00;
  assign cov_full_o = 1'b0;
  assign pass_o     = done_o && (err_cnt_q == '0);
`endif

endmodule

// File: tb/tb_silly_checker.sv
// Self-checking bench for silly_checker: table-driven runs, hand-written corner sequences
// (start/valid collision, asynchronous reset, counter saturation) and a randomized phase,
// all checked against a behavioural model of the checker kept in this file.
module tb_silly_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SILLY_CHK_COVERAGE_EN
  localparam bit CovEn = 1'b1;
`else
  localparam bit CovEn = 1'b0;
`endif

  // Main instance (defaults) signals
  logic       reset_n, start, valid, a, b, c, y;
  logic       busy, done, pass, err_seen, cov_full;
  logic [7:0] vec_cnt, err_cnt, first_err_idx, cov_map;
  logic [2:0] first_err_vec;

  // Saturation instance (CNT_W=2, NUM_VECTORS=3) signals
  logic       s_start, s_valid, s_a, s_b, s_c, s_y;
  logic       s_busy, s_done, s_pass, s_err_seen, s_cov_full;
  logic [1:0] s_vec_cnt, s_err_cnt, s_first_err_idx;
  logic [2:0] s_first_err_vec;
  logic [7:0] s_cov_map;

  silly_checker u_dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .start_i         (start),
    .valid_i         (valid),
    .a_i             (a),
    .b_i             (b),
    .c_i             (c),
    .y_i             (y),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .vec_cnt_o       (vec_cnt),
    .err_cnt_o       (err_cnt),
    .err_seen_o      (err_seen),
    .first_err_vec_o (first_err_vec),
    .first_err_idx_o (first_err_idx),
    .cov_map_o       (cov_map),
    .cov_full_o      (cov_full)
  );

  silly_checker #(
    .NUM_VECTORS (3),
    .CNT_W       (2)
  ) u_sat (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .start_i         (s_start),
    .valid_i         (s_valid),
    .a_i             (s_a),
    .b_i             (s_b),
    .c_i             (s_c),
    .y_i             (s_y),
    .busy_o          (s_busy),
    .done_o          (s_done),
    .pass_o          (s_pass),
    .vec_cnt_o       (s_vec_cnt),
    .err_cnt_o       (s_err_cnt),
    .err_seen_o      (s_err_seen),
    .first_err_vec_o (s_first_err_vec),
    .first_err_idx_o (s_first_err_idx),
    .cov_map_o       (s_cov_map),
    .cov_full_o      (s_cov_full)
  );

  int checks = 0;
  int errors = 0;

  // Truth table of silly: bit {a,b,c} is the expected y (000, 100, 101 are true).
  logic [7:0] truth = 8'h31;

  // Behavioural model of the checker for the default instance.
  int         m_vec, m_err, m_fidx;
  bit         m_seen, m_run, m_done;
  logic [2:0] m_fvec;
  logic [7:0] m_cov;

  typedef struct {
    logic [2:0] abc;
    logic       y;
    logic [7:0] exp_err;
  } vec_t;

  vec_t t1[11];
  vec_t t2[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_vec = 0; m_err = 0; m_fidx = 0; m_seen = 0; m_fvec = 3'b000;
    m_cov = 8'h00; m_run = 0; m_done = 0;
  endtask

  task automatic mdl_step(input bit s, input bit v, input logic [2:0] abc, input logic yy);
    if (s) begin
      mdl_reset();
      m_run = 1;
    end else if (v && m_run) begin
      if (yy != truth[abc]) begin
        if (m_err < 255) m_err++;
        if (!m_seen) begin
          m_seen = 1;
          m_fvec = abc;
          m_fidx = m_vec;
        end
      end
      m_vec++;
      m_cov[abc] = 1'b1;
      if (m_vec == 11) begin
        m_run  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_pass;
    exp_pass = m_done && (m_err == 0) && (!CovEn || m_cov == 8'hFF);
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(m_vec));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    chk({tag, ".err_seen"}, 32'(err_seen), 32'(m_seen));
    chk({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(m_fvec));
    chk({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(m_fidx));
    chk({tag, ".cov_map"}, 32'(cov_map), CovEn ? 32'(m_cov) : 32'h0);
    chk({tag, ".cov_full"}, 32'(cov_full), 32'(CovEn && m_cov == 8'hFF));
  endtask

  // Drive one cycle starting at posedge+1; ends at the next posedge+1 with model updated.
  task automatic cyc(input bit s, input bit v, input logic [2:0] abc, input logic yy,
                     input string tag);
    start = s; valid = v; {a, b, c} = abc; y = yy;
    @(posedge clk);
    #1;
    mdl_step(s, v, abc, yy);
    start = 1'b0; valid = 1'b0;
    check_all(tag);
  endtask

  task automatic s_cyc(input bit s, input bit v, input logic [2:0] abc, input logic yy);
    s_start = s; s_valid = v; {s_a, s_b, s_c} = abc; s_y = yy;
    @(posedge clk);
    #1;
    s_start = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    // Run 1: exhaustive then three more, all correct.
    t1[0] = '{3'd0, 1'b1, 8'd0};  t1[1] = '{3'd1, 1'b0, 8'd0};  t1[2]  = '{3'd2, 1'b0, 8'd0};
    t1[3] = '{3'd3, 1'b0, 8'd0};  t1[4] = '{3'd4, 1'b1, 8'd0};  t1[5]  = '{3'd5, 1'b1, 8'd0};
    t1[6] = '{3'd6, 1'b0, 8'd0};  t1[7] = '{3'd7, 1'b0, 8'd0};  t1[8]  = '{3'd5, 1'b1, 8'd0};
    t1[9] = '{3'd0, 1'b1, 8'd0};  t1[10] = '{3'd4, 1'b1, 8'd0};
    // Run 2: same vectors, y inverted on 011 and 110.
    t2[0] = '{3'd0, 1'b1, 8'd0};  t2[1] = '{3'd1, 1'b0, 8'd0};  t2[2]  = '{3'd2, 1'b0, 8'd0};
    t2[3] = '{3'd3, 1'b1, 8'd1};  t2[4] = '{3'd4, 1'b1, 8'd1};  t2[5]  = '{3'd5, 1'b1, 8'd1};
    t2[6] = '{3'd6, 1'b1, 8'd2};  t2[7] = '{3'd7, 1'b0, 8'd2};  t2[8]  = '{3'd5, 1'b1, 8'd2};
    t2[9] = '{3'd0, 1'b1, 8'd2};  t2[10] = '{3'd4, 1'b1, 8'd2};

    reset_n = 1'b0;
    {start, valid, a, b, c, y} = '0;
    {s_start, s_valid, s_a, s_b, s_c, s_y} = '0;
    mdl_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Run 1: all correct, full coverage
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t1.start");
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, t1[i].abc, t1[i].y, "t1");
      chk("t1.err_tbl", 32'(err_cnt), 32'(t1[i].exp_err));
    end
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.vec_cnt", 32'(vec_cnt), 32'd11);
    chk("t1.pass", 32'(pass), 32'd1);
    chk("t1.cov_map", 32'(cov_map), CovEn ? 32'hFF : 32'h00);
    // valid in DONE is ignored
    cyc(1'b0, 1'b1, 3'd3, 1'b1, "t1.done_ignore");

    // Run 2: two mismatches
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t2.start");
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, t2[i].abc, t2[i].y, "t2");
      chk("t2.err_tbl", 32'(err_cnt), 32'(t2[i].exp_err));
    end
    chk("t2.err_cnt", 32'(err_cnt), 32'd2);
    chk("t2.first_err_vec", 32'(first_err_vec), 32'b011);
    chk("t2.first_err_idx", 32'(first_err_idx), 32'd3);
    chk("t2.pass", 32'(pass), 32'd0);

    // Run 3: only 000 and 100, all correct
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t3.start");
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, (i % 2 == 0) ? 3'd0 : 3'd4, 1'b1, "t3");
    end
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.cov_map", 32'(cov_map), CovEn ? 32'h11 : 32'h00);
    chk("t3.cov_full", 32'(cov_full), 32'd0);
    chk("t3.pass", 32'(pass), CovEn ? 32'd0 : 32'd1);

    // Start colliding with valid after 5 vectors / 1 error
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t4.start");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, t2[i].abc, t2[i].y, "t4");
    chk("t4.pre_err", 32'(err_cnt), 32'd1);
    cyc(1'b1, 1'b1, 3'd3, 1'b1, "t4.collide");
    chk("t4.vec_cnt", 32'(vec_cnt), 32'd0);
    chk("t4.err_cnt", 32'(err_cnt), 32'd0);
    chk("t4.err_seen", 32'(err_seen), 32'd0);
    chk("t4.busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1, 3'd6, 1'b1, "t4.resume");
    chk("t4.resume_vec", 32'(vec_cnt), 32'd1);

    // Asynchronous reset mid-run after 4 vectors
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t5.start");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, t2[i].abc, t2[i].y, "t5");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5.async_busy", 32'(busy), 32'd0);
    chk("t5.async_vec", 32'(vec_cnt), 32'd0);
    chk("t5.async_err", 32'(err_cnt), 32'd0);
    chk("t5.async_seen", 32'(err_seen), 32'd0);
    chk("t5.async_fvec", 32'(first_err_vec), 32'd0);
    mdl_reset();
    check_all("t5.async");
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 3'd3, 1'b1, "t5.idle_ignore");
    cyc(1'b0, 1'b1, 3'd0, 1'b1, "t5.idle_ignore2");
    chk("t5.idle_vec", 32'(vec_cnt), 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, "t5.restart");
    chk("t5.restart_busy", 32'(busy), 32'd1);

    // Randomized phase against the model
    for (int i = 0; i < 300; i++) begin
      logic [2:0] r_abc;
      logic       r_y;
      r_abc = 3'($urandom_range(0, 7));
      r_y   = truth[r_abc] ^ ($urandom_range(0, 4) == 0);
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, r_abc, r_y, "rnd");
    end

    // Small-counter instance: every vector wrong, err_cnt must not wrap
    s_cyc(1'b1, 1'b0, 3'd0, 1'b0);
    s_cyc(1'b0, 1'b1, 3'd0, 1'b0);
    s_cyc(1'b0, 1'b1, 3'd1, 1'b1);
    chk("sat.mid_err", 32'(s_err_cnt), 32'd2);
    chk("sat.mid_busy", 32'(s_busy), 32'd1);
    s_cyc(1'b0, 1'b1, 3'd7, 1'b1);
    chk("sat.err_cnt", 32'(s_err_cnt), 32'd3);
    chk("sat.done", 32'(s_done), 32'd1);
    chk("sat.busy", 32'(s_busy), 32'd0);
    chk("sat.vec_cnt", 32'(s_vec_cnt), 32'd3);
    chk("sat.pass", 32'(s_pass), 32'd0);
    chk("sat.first_idx", 32'(s_first_err_idx), 32'd0);
    s_cyc(1'b0, 1'b1, 3'd2, 1'b1);
    chk("sat.hold_err", 32'(s_err_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/silly_checker.md
# silly_checker

Synthesizable response checker for the `silly` combinational block: the receiving end of the stimulus interface that drives `silly`. Each clock it can accept one sampled vector (a, b, c, y) and compare y against the golden function. It counts vectors and mismatches, captures the first failing vector, and optionally tracks input-space coverage. It sits beside `silly` in on-board self-test builds and is the scoreboard for bench runs.

## Interface
- NUM_VECTORS, default 11: vectors per run (8 exhaustive + 3 random); legal range 1..2^CNT_W-1.
- CNT_W, default 8: width of the counters and the index.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; clears all results and enters RUN
- valid  in  1  a, b, c, y are valid this cycle
- a, b, c  in  1 each  stimulus applied to `silly`
- y  in  1  response observed from `silly`
- busy  out  1  high in RUN
- done  out  1  high in DONE; held until the next start
- pass  out  1  done & err_cnt==0 (& cov_full when coverage compiled in)
- vec_cnt  out  CNT_W  vectors accepted this run
- err_cnt  out  CNT_W  mismatches; saturates at 2^CNT_W-1
- err_seen  out  1  at least one mismatch this run
- first_err_vec  out  3  {a,b,c} of the first mismatch
- first_err_idx  out  CNT_W  vec_cnt value at the first mismatch
- cov_map  out  8  bit {a,b,c} set once that input combination has been seen
- cov_full  out  1  cov_map == 8'hFF

## Operation
- Golden function: y_exp = (~b & ~c) | (a & ~b). It is true for {a,b,c} = 000, 100, 101.
- States:
  - IDLE is the reset state.
  - IDLE --start--> RUN.
  - RUN --accepted vector makes vec_cnt == NUM_VECTORS--> DONE.
  - DONE --start--> RUN.
- A vector is accepted only when valid=1 in RUN and start=0. On acceptance:
  - vec_cnt increments.
  - If y != y_exp: err_cnt increments (saturating). If err_seen was 0, first_err_vec and first_err_idx are captured and err_seen sets.
  - cov_map[{a,b,c}] sets.
- valid in IDLE or DONE is ignored; no result changes.
- start in any state, including mid-run, synchronously clears vec_cnt, err_cnt, err_seen, first_err_vec, first_err_idx and cov_map, then enters RUN.
- start and valid in the same cycle: start wins and the vector is discarded.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous) and the state returns to IDLE.
- Reset values: every output is 0, except cov_full, which is 0 and tied 0 when coverage is compiled out.

## Timing
- All outputs are registered and update on the clk edge that accepts the vector. There is one cycle from valid to visible counts.
- done/busy change on the same edge as the final vector's counts. pass is valid in the cycle done is first high.
- No backpressure; the checker accepts a vector every cycle in RUN.
- err_cnt saturation: at 2^CNT_W-1, further mismatches leave it unchanged. vec_cnt cannot wrap, because the run ends at NUM_VECTORS.

## Configuration
- SILLY_CHK_COVERAGE_EN:
  - Defined: cov_map and cov_full are live, and pass additionally requires cov_full.
  - Undefined: the coverage register is not built, cov_map is tied 8'h00, cov_full is tied 0, and pass = done & err_cnt==0.

## Structure
- silly_pkg holds:
  - the state enum chk_state_t {IDLE, RUN, DONE};
  - the constant NUM_COMBOS = 8;
  - the function silly_golden(a,b,c), shared with benches.
- One sub-module: silly_ref_model, a combinational wrapper around silly_golden that produces y_exp. The FSM, counters and capture logic live in silly_checker.

## Test plan
- Reset, then start, then the 8 exhaustive vectors 000..111 with the correct y, then 3 more correct vectors. Required: done=1 after the 11th, vec_cnt=11, err_cnt=0, pass=1, cov_map=8'hFF.
- Run with y inverted on vectors 3 (011) and 6 (110). Required: err_cnt=2, first_err_vec=3'b011, first_err_idx=3, pass=0.
- Run of 11 vectors using only combinations 000 and 100, all correct:
  - With SILLY_CHK_COVERAGE_EN: cov_map=8'h11, cov_full=0, pass=0.
  - Without it: pass=1.
- Assert start after 5 vectors with 1 error, in the same cycle as valid. Required: the next cycle shows vec_cnt=0, err_cnt=0, err_seen=0, busy=1; the colliding vector is not counted.
- Drop reset_n low mid-run after 4 vectors. Required: all outputs are 0 asynchronously, before the next clk edge. After release the checker is in IDLE, and valid is ignored until start.
- CNT_W=2, NUM_VECTORS=3, all three vectors wrong. Required: err_cnt=3, saturated, with no wrap; done=1.
